usbh_report_decoder_gen: RTL and testbench



---
 rtl/usbh_report_pkg.sv | 29 ++
 rtl/usbh_axis_hyst.sv | 30 +++
 rtl/usbh_report_decoder_gen.sv | 90 +++++++++
 tb/tb_usbh_report_decoder_gen.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/usbh_report_pkg.sv
// usbh_report_pkg: XBOX360 report field offsets and NES button indices
package usbh_report_pkg;
  localparam int HAT_UP = 16;
  localparam int HAT_DOWN = 17;
  localparam int HAT_LEFT = 18;
  localparam int HAT_RIGHT = 19;
  localparam int RPT_START = 20;
  localparam int RPT_BACK = 21;
  localparam int RPT_LB = 24;
  localparam int RPT_RB = 25;
  localparam int RPT_A = 28;
  localparam int RPT_B = 29;
  localparam int RPT_X = 30;
  localparam int RPT_Y = 31;
  localparam int TRIG_LT = 32;
  localparam int TRIG_RT = 40;
  localparam int AXIS_LX = 48;
  localparam int AXIS_LY = 64;
  localparam int AXIS_RX = 80;
  localparam int AXIS_RY = 96;
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START = 3;
  localparam int BTN_UP = 4;
  localparam int BTN_DOWN = 5;
  localparam int BTN_LEFT = 6;
  localparam int BTN_RIGHT = 7;
endpackage

// File: rtl/usbh_axis_hyst.sv
// usbh_axis_hyst: signed stick axis to pos/neg direction with hysteresis; outputs show the state the current sample resolves to
module usbh_axis_hyst #(
  parameter int c_hi = 12000,
  parameter int c_lo = 8000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_clr,
  input  logic [15:0] i_axis,
  output logic        o_pos,
  output logic        o_neg
);
  localparam logic signed [16:0] hi = 17'(c_hi);
  localparam logic signed [16:0] lo = 17'(c_lo);
  logic signed [16:0] v;
  logic pos_q, neg_q;
  assign v = {i_axis[15], i_axis};
  assign o_pos = v > hi ? 1'b1 : v < lo ? 1'b0 : pos_q;
  assign o_neg = v < -hi ? 1'b1 : v > -lo ? 1'b0 : neg_q;
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else if (i_valid) begin
      pos_q <= o_pos;
      neg_q <= o_neg;
    end
  end
endmodule

// File: rtl/usbh_report_decoder_gen.sv
// usbh_report_decoder_gen: XBOX360 HID report to NES buttons with stick hysteresis, autofire, SOCD cleanup and timeout
module usbh_report_decoder_gen
  import usbh_report_pkg::*;
#(
  parameter int c_clk_hz = 48000000,
  parameter int c_autofire_hz = 10,
  parameter int c_timeout_ms = 100,
  parameter int c_stick_hi = 12000,
  parameter int c_stick_lo = 8000,
  parameter int c_trig_thr = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [159:0] i_report,
  input  logic         i_report_valid,
  input  logic         i_autofire_en,
  output logic [7:0]   o_btn,
  output logic         o_btn_valid,
  output logic         o_connected
);
  localparam int ms_div = c_clk_hz / 1000;
  localparam int af_div = c_clk_hz / (2 * c_autofire_hz);
  localparam int pw = $clog2(ms_div + 1);
  localparam int aw = $clog2(af_div + 1);
  localparam int tw = $clog2(c_timeout_ms + 1);
  logic [pw-1:0] pre;
  logic [aw-1:0] div;
  logic [tw-1:0] ms;
  logic [3:0] pos, neg;
  logic [7:0] r_btn, btn_n;
  logic phase, v1, af_a, af_b, tick, expire, up, down, left, right, unused;
  assign tick = pre == pw'(ms_div - 1);
  assign expire = tick && ms == tw'(c_timeout_ms - 1) && !i_report_valid;
  for (genvar g = 0; g < 4; g++) begin : g_axis
    usbh_axis_hyst #(.c_hi(c_stick_hi), .c_lo(c_stick_lo)) u_hyst (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_valid(i_report_valid),
      .i_clr(expire),
      .i_axis(i_report[AXIS_LX + 16*g +: 16]),
      .o_pos(pos[g]),
      .o_neg(neg[g])
    );
  end
  // axis order LX, LY, RX, RY; positive X is right, positive Y is up
  assign up = i_report[HAT_UP] | pos[1] | pos[3];
  assign down = i_report[HAT_DOWN] | neg[1] | neg[3];
  assign left = i_report[HAT_LEFT] | neg[0] | neg[2];
  assign right = i_report[HAT_RIGHT] | pos[0] | pos[2];
  assign btn_n = {right & ~left, left & ~right, down & ~up, up & ~down,
                  i_report[RPT_START], i_report[RPT_BACK],
                  i_report[RPT_B] | i_report[RPT_X], i_report[RPT_A] | i_report[RPT_Y]};
  assign unused = ^{i_report[159:112], i_report[27:26], i_report[23:22], i_report[15:0]};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre <= '0;
      div <= '0;
      ms <= '0;
      phase <= 1'b0;
      v1 <= 1'b0;
      af_a <= 1'b0;
      af_b <= 1'b0;
      r_btn <= '0;
      o_btn <= '0;
      o_btn_valid <= 1'b0;
      o_connected <= 1'b0;
    end else begin
      v1 <= i_report_valid;
      o_btn_valid <= v1;
      div <= div == aw'(af_div - 1) ? '0 : div + 1'b1;
      phase <= div == aw'(af_div - 1) ? ~phase : phase;
      pre <= i_report_valid || tick ? '0 : pre + 1'b1;
      ms <= i_report_valid ? '0 : tick && ms != tw'(c_timeout_ms) ? ms + 1'b1 : ms;
      if (i_report_valid) begin
        r_btn <= btn_n;
        af_a <= {1'b0, i_report[TRIG_LT +: 8]} >= 9'(c_trig_thr) || i_report[RPT_RB];
        af_b <= {1'b0, i_report[TRIG_RT +: 8]} >= 9'(c_trig_thr) || i_report[RPT_LB];
        o_connected <= 1'b1;
      end else if (expire) begin
        r_btn <= '0;
        af_a <= 1'b0;
        af_b <= 1'b0;
        o_connected <= 1'b0;
      end
      o_btn <= {r_btn[BTN_RIGHT:BTN_SELECT],
                r_btn[BTN_B] | (af_b & phase & i_autofire_en),
                r_btn[BTN_A] | (af_a & phase & i_autofire_en)};
    end
  end
endmodule

// File: tb/tb_usbh_report_decoder_gen.sv
// tb_usbh_report_decoder_gen: table-driven vectors with a scoreboard plus timeout, autofire and reset sequences
module tb_usbh_report_decoder_gen;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, af_en = 1'b0;
  logic [159:0] report = '0;
  logic [7:0] btn;
  logic btn_valid, connected;
  int checks = 0, fails = 0;
  typedef struct {logic [7:0] e; logic [7:0] m;} exp_t;
  typedef struct {logic [15:0] b; logic [7:0] lt; logic [15:0] lx, ly, rx, ry; logic [7:0] e;} vec_t;
  exp_t sb[$];
  exp_t x;
  vec_t tbl[17];
  always #5 clk = ~clk;
  usbh_report_decoder_gen #(
    .c_clk_hz(1000), .c_autofire_hz(100), .c_timeout_ms(60),
    .c_stick_hi(12000), .c_stick_lo(8000), .c_trig_thr(128)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_report(report), .i_report_valid(valid),
    .i_autofire_en(af_en), .o_btn(btn), .o_btn_valid(btn_valid), .o_connected(connected)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask
  function automatic logic [159:0] mk(logic [15:0] b, logic [7:0] lt, logic [7:0] rt,
                                      logic [15:0] lx, logic [15:0] ly, logic [15:0] rx, logic [15:0] ry);
    mk = '0;
    mk[31:16] = b;
    mk[39:32] = lt;
    mk[47:40] = rt;
    mk[63:48] = lx;
    mk[79:64] = ly;
    mk[95:80] = rx;
    mk[111:96] = ry;
  endfunction
  task automatic send(logic [15:0] b, logic [7:0] lt, logic [15:0] lx, logic [15:0] ly,
                      logic [15:0] rx, logic [15:0] ry, logic af, logic [7:0] e, logic [7:0] m);
    report = mk(b, lt, 8'd0, lx, ly, rx, ry);
    valid = 1'b1;
    af_en = af;
    sb.push_back('{e, m});
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic af_run(string name);
    int edges = 0, bad = 0, last = -1;
    logic prev = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i > 0 && btn[0] != prev) begin
        if (last >= 0 && i - last != 5) bad++;
        last = i;
        edges++;
      end
      prev = btn[0];
    end
    chk({name, "_edges_ge5"}, 32'(edges >= 5), 1);
    chk({name, "_period_errs"}, bad, 0);
  endtask
  task automatic ones_run(string name, int n);
    int ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ones += int'(btn[0]);
    end
    chk(name, ones, 0);
  endtask
  always @(negedge clk) begin
    if (btn_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL spurious_valid: o_btn_valid=1 with no pending report, o_btn=%0h", btn);
      end else begin
        x = sb.pop_front();
        chk("btn", 32'(btn & x.m), 32'(x.e & x.m));
      end
    end
  end
  initial begin
    tbl[0] = '{16'h1000, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h01};
    tbl[1] = '{16'h0000, 8'd0, 16'd13000, 16'd0, 16'd0, 16'd0, 8'h80};
    tbl[2] = '{16'h0000, 8'd0, 16'd10000, 16'd0, 16'd0, 16'd0, 8'h80};
    tbl[3] = '{16'h0000, 8'd0, 16'd7000, 16'd0, 16'd0, 16'd0, 8'h00};
    tbl[4] = '{16'h0000, 8'd0, 16'h8000, 16'd0, 16'd0, 16'd0, 8'h40};
    tbl[5] = '{16'h0004, 8'd0, 16'd0, 16'd0, 16'd20000, 16'd0, 8'h00};
    tbl[6] = '{16'h0001, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 8'h10};
    tbl[7] = '{16'h0002, 8'd0, 16'd0, 16'd13000, 16'd0, 16'd0, 8'h00};
    tbl[8] = '{16'h0000, 8'd0, 16'd0, -16'sd13000, 16'd0, 16'd0, 8'h20};
    tbl[9] = '{16'hC000, 8'd0, 16'd0, -16'sd9000, 16'd0, 16'd0, 8'h23};
    tbl[10] = '{16'h0030, 8'd0, 16'd0, -16'sd5000, 16'd0, 16'd0, 8'h0C};
    tbl[11] = '{16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, -16'sd12000, 8'h00};
    tbl[12] = '{16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, 16'd12001, 8'h10};
    tbl[13] = '{16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, 16'd12000, 8'h10};
    tbl[14] = '{16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, 16'd8000, 8'h10};
    tbl[15] = '{16'h0000, 8'd0, 16'd0, 16'd0, 16'd0, 16'd7999, 8'h00};
    tbl[16] = '{16'h0100, 8'd200, 16'd0, 16'd0, 16'd0, 16'd0, 8'h00};
    repeat (3) @(negedge clk);
    chk("rst_btn", 32'(btn), 0);
    chk("rst_connected", 32'(connected), 0);
    chk("rst_valid", 32'(btn_valid), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_connected", 32'(connected), 0);
    chk("idle_btn", 32'(btn), 0);
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].b, tbl[i].lt, tbl[i].lx, tbl[i].ly, tbl[i].rx, tbl[i].ry, 1'b0, tbl[i].e, 8'hFF);
      chk("connected_after_report", 32'(connected), 1);
      repeat (3) @(negedge clk);
    end
    send(16'h0000, 8'd200, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 8'h00, 8'hFE);
    af_run("af_lt200");
    af_en = 1'b0;
    repeat (2) @(negedge clk);
    ones_run("af_disabled_ones", 12);
    send(16'h0000, 8'd127, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 8'h00, 8'hFF);
    ones_run("af_lt127_ones", 14);
    send(16'h0000, 8'd128, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 8'h00, 8'hFE);
    af_run("af_lt128");
    send(16'h0010, 8'd0, 16'd13000, 16'd0, 16'd0, 16'd0, 1'b0, 8'h88, 8'hFF);
    repeat (59) @(negedge clk);
    chk("pre_timeout_connected", 32'(connected), 1);
    chk("pre_timeout_btn", 32'(btn), 32'h88);
    @(negedge clk);
    chk("timeout_connected", 32'(connected), 0);
    chk("timeout_btn_lag", 32'(btn), 32'h88);
    @(negedge clk);
    chk("timeout_btn", 32'(btn), 0);
    repeat (80) @(negedge clk);
    chk("timeout_saturate_connected", 32'(connected), 0);
    chk("timeout_saturate_btn", 32'(btn), 0);
    send(16'h1000, 8'd0, 16'd10000, 16'd0, 16'd0, 16'd0, 1'b0, 8'h01, 8'hFF);
    chk("restore_connected", 32'(connected), 1);
    send(16'h0010, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 8'h08, 8'hFF);
    repeat (59) @(negedge clk);
    send(16'h0020, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 8'h04, 8'hFF);
    chk("coincide_connected", 32'(connected), 1);
    @(negedge clk);
    chk("coincide_connected_next", 32'(connected), 1);
    repeat (3) @(negedge clk);
    send(16'h1000, 8'd0, 16'd13000, 16'd0, 16'd0, 16'd0, 1'b0, 8'h81, 8'hFF);
    repeat (3) @(negedge clk);
    chk("held_btn", 32'(btn), 32'h81);
    report = mk(16'h1010, 8'd0, 8'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("midrst_btn", 32'(btn), 0);
    chk("midrst_connected", 32'(connected), 0);
    chk("midrst_valid", 32'(btn_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    send(16'h0000, 8'd0, 16'd10000, 16'd0, 16'd0, 16'd0, 1'b0, 8'h00, 8'hFF);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
